// File: rtl/ag_tcu_fedp_seq.sv
// Sequencer driving one scaled FEDP unit through a multi-step K-reduction,
// feeding each partial sum back as the next accumulator input.
module ag_tcu_fedp_seq #(
    parameter int unsigned LATENCY = 5,
    parameter int unsigned STEPW   = 8,
    parameter int unsigned TAGW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_fmt_s,
    input  logic [STEPW-1:0] req_steps,
    input  logic [31:0]      req_c,
    input  logic [TAGW-1:0]  req_tag,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [8:0]       op_scale,
    output logic             fedp_enable,
    output logic [2:0]       fedp_fmt_s,
    output logic [8:0]       fedp_scale,
    output logic [31:0]      fedp_c_val,
    input  logic [31:0]      fedp_d_val,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAGW-1:0]  rsp_tag,
    output logic             rsp_err
);

    localparam int unsigned WCNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [31:0]       acc, acc_nx;
    logic [STEPW-1:0]  rem, rem_nx;
    logic [WCNTW-1:0]  wcnt, wcnt_nx;
    logic [2:0]        fmt, fmt_nx;
    logic [TAGW-1:0]   tag, tag_nx;
    logic              err, err_nx;
    logic              fmt_ok_c;

    // Legal source formats are i8, u8, i4, u4 (codes 1..4).
    assign fmt_ok_c = (req_fmt_s >= 3'd1) && (req_fmt_s <= 3'd4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            acc   <= '0;
            rem   <= '0;
            wcnt  <= '0;
            fmt   <= '0;
            tag   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            rem   <= rem_nx;
            wcnt  <= wcnt_nx;
            fmt   <= fmt_nx;
            tag   <= tag_nx;
            err   <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        rem_nx      = rem;
        wcnt_nx     = wcnt;
        fmt_nx      = fmt;
        tag_nx      = tag;
        err_nx      = err;
        req_ready   = 1'b0;
        op_ready    = 1'b0;
        fedp_enable = 1'b0;
        fedp_scale  = '0;
        rsp_valid   = 1'b0;

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    fmt_nx = req_fmt_s;
                    rem_nx = req_steps;
                    tag_nx = req_tag;
                    acc_nx = req_c;
                    if (!fmt_ok_c) begin
                        err_nx   = 1'b1;
                        state_nx = S_RESP;
                    end else if (req_steps == '0) begin
                        state_nx = S_RESP;
                    end else begin
                        state_nx = S_ISSUE;
                    end
                end
            end
            // Pipeline stays frozen while stalled: nothing is in flight here.
            S_ISSUE: begin
                op_ready    = 1'b1;
                fedp_enable = op_valid;
                fedp_scale  = op_scale;
                if (op_valid) begin
                    wcnt_nx  = WCNTW'(LATENCY - 1);
                    rem_nx   = rem - STEPW'(1);
                    state_nx = S_WAIT;
                end
            end
            // Keep clocking the FEDP; whatever enters behind our beat is ignored.
            S_WAIT: begin
                fedp_enable = 1'b1;
                if (wcnt == '0) begin
                    acc_nx   = fedp_d_val;
                    state_nx = (rem != '0) ? S_ISSUE : S_RESP;
                end else begin
                    wcnt_nx = wcnt - WCNTW'(1);
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    err_nx   = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign fedp_fmt_s = fmt;
    assign fedp_c_val = acc;
    assign rsp_data   = acc;
    assign rsp_tag    = tag;
    assign rsp_err    = err;

endmodule

// File: tb/tb_ag_tcu_fedp_seq.sv
// Self-checking bench: directed and randomized jobs against a sum-of-shifted-dots model.
module tb_ag_tcu_fedp_seq;

    localparam int unsigned LAT   = 5;
    localparam int unsigned STEPW = 8;
    localparam int unsigned TAGW  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_fmt_s;
    logic [STEPW-1:0] req_steps;
    logic [31:0]      req_c;
    logic [TAGW-1:0]  req_tag;
    logic             op_valid;
    logic             op_ready;
    logic [8:0]       op_scale;
    logic             fedp_enable;
    logic [2:0]       fedp_fmt_s;
    logic [8:0]       fedp_scale;
    logic [31:0]      fedp_c_val;
    logic [31:0]      fedp_d_val;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAGW-1:0]  rsp_tag;
    logic             rsp_err;

    always #5 clk = ~clk;

    ag_tcu_fedp_seq #(.LATENCY(LAT), .STEPW(STEPW), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_fmt_s(req_fmt_s),
        .req_steps(req_steps), .req_c(req_c), .req_tag(req_tag),
        .op_valid(op_valid), .op_ready(op_ready), .op_scale(op_scale),
        .fedp_enable(fedp_enable), .fedp_fmt_s(fedp_fmt_s), .fedp_scale(fedp_scale),
        .fedp_c_val(fedp_c_val), .fedp_d_val(fedp_d_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    // FEDP stand-in: d = c + (dot << scale), advancing only on enabled cycles.
    logic [31:0] cur_dot;
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (fedp_enable) begin
            pipe[0] <= fedp_c_val + (cur_dot << fedp_scale);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign fedp_d_val = pipe[LAT-1];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] dots [16];
    int unsigned scl  [16];
    int unsigned stl  [16];

    task automatic set_step(input int i, input logic [31:0] d, input int unsigned s, input int unsigned st);
        dots[i] = d;
        scl[i]  = s;
        stl[i]  = st;
    endtask

    // Runs one job; abort_step >= 0 asserts reset in the WAIT phase of that step.
    task automatic run_job(input logic [2:0] fmt, input int steps, input logic [31:0] c,
                           input logic [TAGW-1:0] tag, input int bp, input int abort_step);
        logic [31:0] exp_acc;
        logic        legal;
        legal   = (fmt >= 3'd1) && (fmt <= 3'd4);
        exp_acc = c;

        @(negedge clk);
        req_valid = 1'b1; req_fmt_s = fmt; req_steps = STEPW'(steps);
        req_c = c; req_tag = tag;
        #1;
        check("req_ready_idle", req_ready, 1);
        check("rsp_valid_idle", rsp_valid, 0);
        @(negedge clk);
        req_valid = 1'b0; req_c = $urandom; req_tag = TAGW'($urandom);

        if (legal) begin
            for (int s = 0; s < steps; s++) begin
                for (int k = 0; k < int'(stl[s]); k++) begin
                    op_valid = 1'b0; op_scale = 9'($urandom);
                    #1;
                    check("stall_op_ready", op_ready, 1);
                    check("stall_enable", fedp_enable, 0);
                    check("stall_req_ready", req_ready, 0);
                    @(negedge clk);
                end
                op_valid = 1'b1; op_scale = 9'(scl[s]); cur_dot = dots[s];
                #1;
                check("issue_op_ready", op_ready, 1);
                check("issue_enable", fedp_enable, 1);
                check("issue_fmt", 32'(fedp_fmt_s), 32'(fmt));
                check("issue_scale", 32'(fedp_scale), scl[s]);
                check("issue_c_val", fedp_c_val, exp_acc);
                check("issue_rsp_valid", rsp_valid, 0);
                exp_acc = exp_acc + (dots[s] << scl[s]);
                @(negedge clk);
                for (int w = 0; w < int'(LAT); w++) begin
                    op_valid = 1'($urandom); cur_dot = $urandom; op_scale = 9'($urandom);
                    #1;
                    check("wait_op_ready", op_ready, 0);
                    check("wait_enable", fedp_enable, 1);
                    check("wait_fmt", 32'(fedp_fmt_s), 32'(fmt));
                    check("wait_rsp_valid", rsp_valid, 0);
                    if (s == abort_step && w == 1) begin
                        reset = 1'b1;
                        #1;
                        check("abort_req_ready", req_ready, 1);
                        check("abort_rsp_valid", rsp_valid, 0);
                        check("abort_op_ready", op_ready, 0);
                        check("abort_enable", fedp_enable, 0);
                        check("abort_rsp_data", rsp_data, 0);
                        @(negedge clk);
                        reset = 1'b0; op_valid = 1'b0;
                        return;
                    end
                    @(negedge clk);
                end
            end
        end
        op_valid = 1'b0;
        rsp_ready = (bp == 0);
        #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, exp_acc);
        check("rsp_tag", 32'(rsp_tag), 32'(tag));
        check("rsp_err", rsp_err, !legal);
        check("rsp_req_ready", req_ready, 0);
        check("rsp_op_ready", op_ready, 0);
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            rsp_ready = (b == bp - 1);
            #1;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, exp_acc);
            check("bp_rsp_tag", 32'(rsp_tag), 32'(tag));
            check("bp_rsp_err", rsp_err, !legal);
            check("bp_req_ready", req_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("done_rsp_valid", rsp_valid, 0);
        check("done_req_ready", req_ready, 1);
        check("done_err_clear", rsp_err, 0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_fmt_s = '0; req_steps = '0; req_c = '0; req_tag = '0;
        op_valid = 1'b0; op_scale = '0; rsp_ready = 1'b0; cur_dot = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_op_ready", op_ready, 0);
        check("rst_enable", fedp_enable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_tag", 32'(rsp_tag), 0);
        check("rst_rsp_err", rsp_err, 0);
        reset = 1'b0;

        // Single step: 10 + 16 = 26
        set_step(0, 32'd16, 0, 0);
        run_job(3'd1, 1, 32'd10, 4'h5, 0, -1);
        // Chained: 16 + 32 + 64 = 112
        set_step(0, 32'd16, 0, 0); set_step(1, 32'd16, 1, 0); set_step(2, 32'd16, 2, 0);
        run_job(3'd2, 3, 32'd0, 4'h9, 0, -1);
        // Operand stall of 4 cycles
        set_step(0, 32'd16, 0, 4);
        run_job(3'd1, 1, 32'd10, 4'h3, 0, -1);
        // Zero steps and illegal format
        run_job(3'd4, 0, 32'h0000_1234, 4'hA, 0, -1);
        run_job(3'd6, 2, 32'hDEAD_BEEF, 4'hC, 1, -1);
        // Backpressure with two's-complement wrap
        set_step(0, 32'd1, 0, 0);
        run_job(3'd3, 1, 32'h7FFF_FFFF, 4'hF, 5, -1);
        // Reset during step 2, then a clean job
        set_step(0, 32'd16, 0, 0); set_step(1, 32'd16, 1, 0); set_step(2, 32'd16, 2, 0);
        run_job(3'd1, 3, 32'd100, 4'h2, 0, 1);
        set_step(0, 32'd16, 3, 1);
        run_job(3'd2, 1, 32'd5, 4'h6, 0, -1);

        for (int j = 0; j < 30; j++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++)
                set_step(i, $urandom, $urandom_range(0, 8), $urandom_range(0, 3));
            run_job(3'($urandom_range(0, 7)), n, $urandom, TAGW'($urandom),
                    $urandom_range(0, 3), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
